// File: rtl/read_arbiter_2to1_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : read_arbiter_2to1_pkg
//  Brief    : Shared widths and grant-FSM state encoding for the 2:1 read
//             arbiter and its order FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
package read_arbiter_2to1_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/read_arbiter_2to1_order_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : read_arbiter_2to1_order_fifo
//  Brief    : DEPTH x 1-bit FIFO recording which manager owns each
//             outstanding burst, oldest entry presented at head.
//  Revision : 1.0 - initial release
// ============================================================================
module read_arbiter_2to1_order_fifo #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            push_data,
  input  logic            pop,
  output logic            head,
  output logic            empty,
  output logic            full,
  output logic [PTRW:0]   count
);

  localparam logic [PTRW:0] FULL_COUNT = (PTRW+1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;

  // Storage, pointers (wrap naturally as DEPTH is a power of two) and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

endmodule
`default_nettype wire

// File: rtl/read_arbiter_2to1.sv
`default_nettype none
// ============================================================================
//  Module   : read_arbiter_2to1
//  Brief    : Shares one read subordinate between managers m0 and m1.
//             Round-robin request grant locked until handshake; responses
//             steered by an order FIFO, popped on the rlast beat.
//  Revision : 1.0 - initial release
// ============================================================================
module read_arbiter_2to1
  import read_arbiter_2to1_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  // manager 0
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [ADDR_W-1:0] m0_araddr,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [ID_W-1:0]   m0_rid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rlast,
  // manager 1
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [ADDR_W-1:0] m1_araddr,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ID_W-1:0]   m1_rid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rlast,
  // subordinate
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ID_W-1:0]   s_arid,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [ID_W-1:0]   s_rid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rlast,
  // status
  output logic [PTRW:0]     outstanding
);

  arb_state_e state, next_state;
  logic       g, next_g;
  logic       last_grant;
  logic       sel_arvalid;
  logic       push;
  logic       pop;
  logic       head;
  logic       empty;
  logic       full;

  // Grant FSM state, locked manager and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      g          <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= next_state;
      g     <= next_g;
      if (push) begin
        last_grant <= g;
      end
    end
  end

  // Next-state/grant selection and request-channel muxing.
  always_comb begin
    next_state  = state;
    next_g      = g;
    push        = 1'b0;
    s_arvalid   = 1'b0;
    m0_arready  = 1'b0;
    m1_arready  = 1'b0;
    sel_arvalid = g ? m1_arvalid : m0_arvalid;
    s_arid      = g ? m1_arid    : m0_arid;
    s_araddr    = g ? m1_araddr  : m0_araddr;
    case (state)
      IDLE: begin
        // Entry needs room in the order FIFO; the lock can then never overflow it.
        if ((m0_arvalid || m1_arvalid) && !full) begin
          next_state = LOCK;
          if (m0_arvalid && m1_arvalid) begin
            next_g = ~last_grant;
          end else begin
            next_g = m1_arvalid;
          end
        end
      end
      LOCK: begin
        s_arvalid  = sel_arvalid;
        m0_arready = !g && s_arready;
        m1_arready =  g && s_arready;
        if (sel_arvalid && s_arready) begin
          push       = 1'b1;
          next_state = IDLE;
        end else if (!sel_arvalid) begin
          // Requester withdrew its request: release the lock without a push.
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Response steering to the manager at the FIFO head; stall when empty.
  always_comb begin
    m0_rvalid = !empty && !head && s_rvalid;
    m1_rvalid = !empty &&  head && s_rvalid;
    s_rready  = !empty && (head ? m1_rready : m0_rready);
    pop       = s_rvalid && s_rready && s_rlast;
  end

  assign m0_rid   = s_rid;
  assign m0_rdata = s_rdata;
  assign m0_rlast = s_rlast;
  assign m1_rid   = s_rid;
  assign m1_rdata = s_rdata;
  assign m1_rlast = s_rlast;

  read_arbiter_2to1_order_fifo #(
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_order_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (g),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .count     (outstanding)
  );

endmodule
`default_nettype wire

// File: tb/tb_read_arbiter_2to1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_read_arbiter_2to1
//  Brief    : Self-checking bench for read_arbiter_2to1 with a queue-based
//             reference model of grant ownership and burst order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_read_arbiter_2to1;

  localparam int DEPTH = 4;
  localparam int PTRW  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [3:0]  m0_arid, m0_rid;
  logic [31:0] m0_araddr, m0_rdata;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [3:0]  m1_arid, m1_rid;
  logic [31:0] m1_araddr, m1_rdata;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [3:0]  s_arid, s_rid;
  logic [31:0] s_araddr, s_rdata;
  logic [PTRW:0] outstanding;

  read_arbiter_2to1 #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_arid(m0_arid), .m0_araddr(m0_araddr),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_arid(m1_arid), .m1_araddr(m1_araddr),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rlast(m1_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rlast(s_rlast),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: who holds the grant, round-robin history, burst owners in order.
  int          lock;
  bit          last;
  int          q[$];
  int          sub_q[$];
  int          beat;
  int          pend[2];
  bit [31:0]   addr[2];
  bit [3:0]    id[2];
  bit          rr[2];
  int          dut_grants[$];
  // Stimulus knobs
  int          p_arready, p_rvalid, p_rready, force_len;
  bit          data_seq, pat_en;
  int          pat_idx;
  bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    lock = -1; last = 1'b1; beat = 0;
    q.delete(); sub_q.delete(); dut_grants.delete();
    pend[0] = 0; pend[1] = 0;
    pat_idx = 0;
  endtask

  task automatic drive();
    m0_arvalid = pend[0] > 0; m0_araddr = addr[0]; m0_arid = id[0];
    m1_arvalid = pend[1] > 0; m1_araddr = addr[1]; m1_arid = id[1];
    s_arready  = $urandom_range(99) < p_arready;
    rr[0] = $urandom_range(99) < p_rready;
    rr[1] = pat_en ? pat[pat_idx % 4] : ($urandom_range(99) < p_rready);
    m0_rready = rr[0]; m1_rready = rr[1];
    s_rid   = 4'($urandom);
    s_rdata = $urandom;
    s_rlast = 1'b0;
    s_rvalid = 1'b0;
    if (sub_q.size() > 0 && $urandom_range(99) < p_rvalid) begin
      s_rvalid = 1'b1;
      s_rlast  = (beat == sub_q[0] - 1);
      if (data_seq) s_rdata = 32'hA0 + beat;
    end
  endtask

  task automatic check();
    int h;
    chk("s_arvalid", s_arvalid, (lock >= 0) && (pend[lock > 0 ? 1 : 0] > 0));
    chk("m0_arready", m0_arready, (lock == 0) && s_arready);
    chk("m1_arready", m1_arready, (lock == 1) && s_arready);
    if (lock >= 0) begin
      chk("s_araddr", s_araddr, addr[lock]);
      chk("s_arid", s_arid, id[lock]);
    end
    if (m0_arready && m0_arvalid) dut_grants.push_back(0);
    if (m1_arready && m1_arvalid) dut_grants.push_back(1);
    chk("outstanding", outstanding, q.size());
    if (q.size() == 0) begin
      chk("s_rready_empty", s_rready, 0);
      chk("m0_rvalid_empty", m0_rvalid, 0);
      chk("m1_rvalid_empty", m1_rvalid, 0);
    end else begin
      h = q[0];
      chk("m0_rvalid", m0_rvalid, (h == 0) && s_rvalid);
      chk("m1_rvalid", m1_rvalid, (h == 1) && s_rvalid);
      chk("s_rready", s_rready, rr[h]);
      if (s_rvalid) begin
        chk("rdata", h ? m1_rdata : m0_rdata, s_rdata);
        chk("rlast", h ? m1_rlast : m0_rlast, s_rlast);
        chk("rid", h ? m1_rid : m0_rid, s_rid);
      end
    end
  endtask

  task automatic update();
    int qs;
    int w;
    qs = q.size();
    if (lock >= 0 && pend[lock] > 0 && s_arready) begin
      q.push_back(lock);
      sub_q.push_back(force_len > 0 ? force_len : int'($urandom_range(4, 1)));
      last = lock[0];
      pend[lock]--;
      addr[lock] = $urandom;
      id[lock]   = 4'($urandom);
      lock = -1;
    end else if (lock < 0 && (pend[0] > 0 || pend[1] > 0) && qs < DEPTH) begin
      if (pend[0] > 0 && pend[1] > 0) w = last ? 0 : 1;
      else w = (pend[0] > 0) ? 0 : 1;
      lock = w;
    end
    if (s_rvalid && qs > 0 && rr[q[0]]) begin
      if (s_rlast) begin
        void'(q.pop_front());
        void'(sub_q.pop_front());
        beat = 0;
      end else begin
        beat++;
      end
    end
    pat_idx++;
  endtask

  task automatic cycle();
    drive();
    #2;
    check();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((pend[0] > 0 || pend[1] > 0 || sub_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("idle_timeout", n < budget, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    m0_arvalid = 0; m1_arvalid = 0; s_arready = 0; s_rvalid = 0; s_rlast = 0;
    m0_rready = 0; m1_rready = 0;
    #1;
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_arready", {m0_arready, m1_arready}, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_s_rready", s_rready, 0);
    chk("rst_outstanding", outstanding, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    addr[0] = 0; addr[1] = 0; id[0] = 0; id[1] = 0;
    p_arready = 100; p_rvalid = 100; p_rready = 100; force_len = 0;
    data_seq = 0; pat_en = 0;
    m0_araddr = 0; m1_araddr = 0; m0_arid = 0; m1_arid = 0; s_rid = 0; s_rdata = 0;
    @(posedge clk); #1;
    do_reset();

    // Single m0 read of a fixed 4-beat burst 0xA0..0xA3
    addr[0] = 32'h1000; id[0] = 4'd3; pend[0] = 1;
    force_len = 4; data_seq = 1;
    run_until_idle(40);
    chk("t1_grants", dut_grants.size(), 1);
    if (dut_grants.size() > 0) chk("t1_grant0", dut_grants[0], 0);
    data_seq = 0; force_len = 0;

    // Both managers requesting from reset: alternation m0,m1,m0,m1
    do_reset();
    pend[0] = 2; pend[1] = 2;
    run_until_idle(100);
    chk("t2_grants", dut_grants.size(), 4);
    for (int i = 0; i < 4 && i < dut_grants.size(); i++) chk("t2_grant_order", dut_grants[i], i % 2);

    // Order FIFO full: 5 requests, 4 accepted while responses are withheld
    p_rvalid = 0; pend[0] = 5;
    for (int i = 0; i < 20; i++) cycle();
    chk("t3_outstanding_full", outstanding, 4);
    chk("t3_fifth_blocked", m0_arready, 0);
    p_rvalid = 100;
    run_until_idle(100);

    // m1 burst under rready pattern 1,0,0,1
    pend[1] = 1; force_len = 4; pat_en = 1;
    run_until_idle(60);
    pat_en = 0; force_len = 0;

    // Randomised traffic: push/pop overlap, pointer wrap, backpressure
    p_arready = 70; p_rvalid = 70; p_rready = 70;
    pend[0] = 15; pend[1] = 15;
    run_until_idle(3000);
    p_arready = 100; p_rvalid = 100; p_rready = 100;

    // Reset while locked with 2 outstanding
    do_reset();
    p_rvalid = 0;
    pend[0] = 2;
    for (int i = 0; i < 20 && q.size() < 2; i++) cycle();
    pend[0] = 1;
    for (int i = 0; i < 10 && lock < 0; i++) cycle();
    chk("t6_locked", lock >= 0, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_s_arvalid", s_arvalid, 0);
    chk("t6_m0_arready", m0_arready, 0);
    chk("t6_outstanding", outstanding, 0);
    chk("t6_s_rready", s_rready, 0);
    do_reset();
    p_rvalid = 100;
    pend[1] = 1;
    run_until_idle(40);
    chk("t6_grants", dut_grants.size(), 1);
    if (dut_grants.size() > 0) chk("t6_grant_m1", dut_grants[0], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
